// File: rtl/usr_shifter_n_if.sv
// ---------------------------------------------------------------------------
// usr_shifter_n_if
// Bus bundle for the universal shift register usr_shifter_n.
//   master : drives par_in, load, mode, serin, start, shift_amt and
//            observes data_out, serout, busy, done
//   slave  : the shifter itself (the opposite directions)
// ---------------------------------------------------------------------------
interface usr_shifter_n_if #(
   parameter int N  = 64,
   parameter int CW = 7
);
   logic [N-1:0]  par_in;
   logic          load;
   logic [1:0]    mode;
   logic          serin;
   logic          start;
   logic [CW-1:0] shift_amt;
   logic [N-1:0]  data_out;
   logic          serout;
   logic          busy;
   logic          done;

   modport master (
      output par_in, load, mode, serin, start, shift_amt,
      input  data_out, serout, busy, done
   );

   modport slave (
      input  par_in, load, mode, serin, start, shift_amt,
      output data_out, serout, busy, done
   );
endinterface

// File: rtl/usr_shifter_n.sv
// ---------------------------------------------------------------------------
// usr_shifter_n
// Parametrised universal shift register: parallel load, logical shift
// left/right with serial fill, rotate left/right. A start/busy/done
// sequencer applies a multi-bit shift count one position per clock.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   sh    : usr_shifter_n_if.slave bundle
//             par_in/load        parallel load (highest priority)
//             mode               00 srl, 01 sll, 10 ror, 11 rol
//             serin              fill bit for logical shifts
//             start/shift_amt    launch a shift of shift_amt steps
//             data_out/serout    register contents / last bit shifted out
//             busy/done          SHIFT in progress / completion pulse
// ---------------------------------------------------------------------------
module usr_shifter_n #(
   parameter int N  = 64,
   parameter int CW = 7
) (
   input  logic            clock,
   input  logic            reset,
   usr_shifter_n_if.slave  sh
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        state_q,  state_d;
   logic [N-1:0]  data_q,   data_d;
   logic          serout_q, serout_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [1:0]    mode_q,   mode_d;

   // One shift/rotate step; result is {bit shifted out, new register value}.
   function automatic logic [N:0] shift_step(
      input logic [N-1:0] d,
      input logic [1:0]   m,
      input logic         si
   );
      case (m)
         2'b00:   shift_step = {d[0],   si,       d[N-1:1]};
         2'b01:   shift_step = {d[N-1], d[N-2:0], si};
         2'b10:   shift_step = {d[0],   d[0],     d[N-1:1]};
         default: shift_step = {d[N-1], d[N-2:0], d[N-1]};
      endcase
   endfunction

   logic [N:0] step_res;

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      serout_d = serout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      step_res = shift_step(data_q, mode_q, sh.serin);

      if (sh.load) begin
         // Load aborts any operation in flight and suppresses its done pulse.
         data_d  = sh.par_in;
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sh.start) begin
                  mode_d = sh.mode;
                  cnt_d  = sh.shift_amt;
                  if (sh.shift_amt != '0) begin
                     state_d = ST_SHIFT;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               data_d   = step_res[N-1:0];
               serout_d = step_res[N];
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            ST_DONE: begin
               // A shifted op pulsed done on entry; a zero-count op reaches
               // DONE with done low and pulses it on the way back to IDLE.
               state_d = ST_IDLE;
               done_d  = ~done_q;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         serout_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         mode_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         serout_q <= serout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
      end
   end

   assign sh.data_out = data_q;
   assign sh.serout   = serout_q;
   assign sh.busy     = busy_q;
   assign sh.done     = done_q;

endmodule

// File: tb/tb_usr_shifter_n.sv
// ---------------------------------------------------------------------------
// tb_usr_shifter_n
// Directed testbench for usr_shifter_n (N=64, CW=7).
// ---------------------------------------------------------------------------
module tb_usr_shifter_n;
   localparam int N  = 64;
   localparam int CW = 7;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   usr_shifter_n_if #(.N(N), .CW(CW)) ifc ();

   usr_shifter_n #(.N(N), .CW(CW)) dut (
      .clock (clock),
      .reset (reset),
      .sh    (ifc.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] v);
      ifc.par_in = v;
      ifc.load   = 1'b1;
      tick();
      ifc.load   = 1'b0;
   endtask

   // Launch one op and watch a window of amt+4 cycles after the start edge.
   // da is the index (0 = right after the start edge) of the first done.
   task automatic run_op(input logic [1:0] m, input int amt, input logic si,
                         output int bc, output int dc, output int da);
      ifc.mode      = m;
      ifc.shift_amt = CW'(amt);
      ifc.serin     = si;
      ifc.start     = 1'b1;
      tick();
      ifc.start = 1'b0;
      bc = 0; dc = 0; da = -1;
      for (int i = 0; i < amt + 4; i++) begin
         if (ifc.busy) bc++;
         if (ifc.done) begin
            dc++;
            if (da < 0) da = i;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++; if (ifc.data_out !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", ifc.data_out); end
      checks++; if (ifc.serout !== 1'b0) begin errors++; $display("FAIL rst_serout got %b exp 0", ifc.serout); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ifc.busy); end
      checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", ifc.done); end
      reset = 1'b0;
      tick();
      checks++; if (ifc.data_out !== '0) begin errors++; $display("FAIL post_rst_data got %h exp 0", ifc.data_out); end
   endtask

   task automatic test_load();
      do_load(64'h0000_0001_0000_0000);
      checks++; if (ifc.data_out !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL load_data got %h exp 0000000100000000", ifc.data_out); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL load_busy got %b exp 0", ifc.busy); end
   endtask

   task automatic test_rotate_left();
      int bc, dc, da;
      run_op(2'b11, 4, 1'b0, bc, dc, da);
      checks++; if (ifc.data_out !== 64'h0000_0010_0000_0000) begin errors++; $display("FAIL rol_data got %h exp 0000001000000000", ifc.data_out); end
      checks++; if (bc !== 4) begin errors++; $display("FAIL rol_busy_cycles got %0d exp 4", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL rol_done_count got %0d exp 1", dc); end
      checks++; if (da !== 4) begin errors++; $display("FAIL rol_done_at got %0d exp 4", da); end
      checks++; if (ifc.serout !== 1'b0) begin errors++; $display("FAIL rol_serout got %b exp 0", ifc.serout); end
   endtask

   task automatic test_logical_right();
      int bc, dc, da;
      do_load(64'h8);
      run_op(2'b00, 3, 1'b1, bc, dc, da);
      checks++; if (ifc.data_out !== 64'hE000_0000_0000_0001) begin errors++; $display("FAIL srl3_data got %h exp e000000000000001", ifc.data_out); end
      checks++; if (ifc.serout !== 1'b0) begin errors++; $display("FAIL srl3_serout got %b exp 0", ifc.serout); end
      do_load(64'h8);
      run_op(2'b00, 4, 1'b1, bc, dc, da);
      checks++; if (ifc.data_out !== 64'hF000_0000_0000_0000) begin errors++; $display("FAIL srl4_data got %h exp f000000000000000", ifc.data_out); end
      checks++; if (ifc.serout !== 1'b1) begin errors++; $display("FAIL srl4_serout got %b exp 1", ifc.serout); end
   endtask

   task automatic test_boundaries();
      int bc, dc, da;
      do_load(64'hA5);
      run_op(2'b01, 0, 1'b1, bc, dc, da);
      checks++; if (bc !== 0) begin errors++; $display("FAIL amt0_busy_cycles got %0d exp 0", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL amt0_done_count got %0d exp 1", dc); end
      checks++; if (da !== 1) begin errors++; $display("FAIL amt0_done_at got %0d exp 1", da); end
      checks++; if (ifc.data_out !== 64'hA5) begin errors++; $display("FAIL amt0_data got %h exp a5", ifc.data_out); end

      do_load(64'h1234_5678_9ABC_DEF0);
      run_op(2'b10, 64, 1'b1, bc, dc, da);
      checks++; if (ifc.data_out !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL ror64_data got %h exp 123456789abcdef0", ifc.data_out); end
      checks++; if (bc !== 64) begin errors++; $display("FAIL ror64_busy_cycles got %0d exp 64", bc); end
      checks++; if (ifc.serout !== 1'b0) begin errors++; $display("FAIL ror64_serout got %b exp 0", ifc.serout); end

      do_load(64'hFFFF_FFFF_FFFF_FFFF);
      run_op(2'b01, 65, 1'b0, bc, dc, da);
      checks++; if (ifc.data_out !== '0) begin errors++; $display("FAIL sll65_data got %h exp 0", ifc.data_out); end
      checks++; if (bc !== 65) begin errors++; $display("FAIL sll65_busy_cycles got %0d exp 65", bc); end
      checks++; if (da !== 65) begin errors++; $display("FAIL sll65_done_at got %0d exp 65", da); end
   endtask

   task automatic test_abort();
      int dc;
      do_load(64'hC000_0000_0000_0000);
      ifc.mode = 2'b01; ifc.shift_amt = CW'(10); ifc.serin = 1'b0; ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      tick();
      tick();
      ifc.par_in = 64'hDEAD_BEEF_0000_1111;
      ifc.load   = 1'b1;
      tick();
      ifc.load = 1'b0;
      checks++; if (ifc.data_out !== 64'hDEAD_BEEF_0000_1111) begin errors++; $display("FAIL abort_data got %h exp deadbeef00001111", ifc.data_out); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", ifc.busy); end
      checks++; if (ifc.serout !== 1'b1) begin errors++; $display("FAIL abort_serout got %b exp 1", ifc.serout); end
      dc = 0;
      for (int i = 0; i < 12; i++) begin
         if (ifc.done || ifc.busy) dc++;
         tick();
      end
      checks++; if (dc !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dc); end
      checks++; if (ifc.data_out !== 64'hDEAD_BEEF_0000_1111) begin errors++; $display("FAIL abort_hold got %h exp deadbeef00001111", ifc.data_out); end
   endtask

   task automatic test_start_in_shift();
      do_load(64'h1);
      ifc.mode = 2'b11; ifc.shift_amt = CW'(2); ifc.serin = 1'b0; ifc.start = 1'b1;
      tick();
      ifc.mode = 2'b00; ifc.shift_amt = CW'(5); ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      tick();
      checks++; if (ifc.data_out !== 64'h4) begin errors++; $display("FAIL ign_start_data got %h exp 4", ifc.data_out); end
      checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL ign_start_done got %b exp 1", ifc.done); end
      tick();
      checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL ign_start_idle got busy %b done %b exp 0 0", ifc.busy, ifc.done); end
      checks++; if (ifc.data_out !== 64'h4) begin errors++; $display("FAIL ign_start_hold got %h exp 4", ifc.data_out); end
   endtask

   task automatic test_load_start_together();
      ifc.par_in = 64'h55; ifc.load = 1'b1;
      ifc.mode = 2'b01; ifc.shift_amt = CW'(3); ifc.start = 1'b1;
      tick();
      ifc.load = 1'b0; ifc.start = 1'b0;
      checks++; if (ifc.data_out !== 64'h55) begin errors++; $display("FAIL ld_st_data got %h exp 55", ifc.data_out); end
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL ld_st_busy got %b exp 0", ifc.busy); end
      tick();
      checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL ld_st_idle got busy %b done %b exp 0 0", ifc.busy, ifc.done); end
      checks++; if (ifc.data_out !== 64'h55) begin errors++; $display("FAIL ld_st_hold got %h exp 55", ifc.data_out); end
   endtask

   task automatic test_async_reset();
      int bc, dc, da;
      do_load(64'hFFFF_0000);
      ifc.mode = 2'b10; ifc.shift_amt = CW'(20); ifc.serin = 1'b0; ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (ifc.data_out !== '0) begin errors++; $display("FAIL arst_data got %h exp 0", ifc.data_out); end
      checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.serout !== 1'b0) begin errors++; $display("FAIL arst_ctrl got busy %b done %b serout %b exp 0 0 0", ifc.busy, ifc.done, ifc.serout); end
      #2;
      reset = 1'b0;
      tick();
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL arst_idle got busy %b exp 0", ifc.busy); end
      do_load(64'h3);
      run_op(2'b01, 2, 1'b1, bc, dc, da);
      checks++; if (ifc.data_out !== 64'hF) begin errors++; $display("FAIL arst_fresh_data got %h exp f", ifc.data_out); end
      checks++; if (dc !== 1 || da !== 2) begin errors++; $display("FAIL arst_fresh_done got count %0d at %0d exp 1 at 2", dc, da); end
      checks++; if (ifc.serout !== 1'b0) begin errors++; $display("FAIL arst_fresh_serout got %b exp 0", ifc.serout); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ifc.par_in    = '0;
      ifc.load      = 1'b0;
      ifc.mode      = 2'b00;
      ifc.serin     = 1'b0;
      ifc.start     = 1'b0;
      ifc.shift_amt = '0;
      test_reset();
      test_load();
      test_rotate_left();
      test_logical_right();
      test_boundaries();
      test_abort();
      test_start_in_shift();
      test_load_start_together();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
